decode_issue_stage: RTL
=======================

Name: decode_issue_stage

Overview:
- Decode/issue stage that produces the ALU command stream: ALU function, register indices, immediate and operand-select.
- Sits between instruction fetch and the register-read/ALU stage.
- Accepts one fetched RV32I word per valid/ready handshake and decodes the integer subset the ALU implements.
- Holds decoded results in a two-entry skid buffer so fetch-side ready is a registered signal.
- Flags and counts unsupported encodings.

Parameters:
- CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous discard of all buffered entries
- in_valid  input  1  fetch offers in_instr/in_pc
- in_ready  output  1  stage can accept; registered
- in_instr  input  32  instruction word
- in_pc  input  32  instruction address
- out_valid  output  1  decoded entry available
- out_ready  input  1  downstream accepts entry
- out_alu_func  output  ALU_func_t  ADD,SUB,SLL,SLT,XOR,SRL,SRA,AND,OR,ADDI,EQL
- out_rs1  output  5  source register 1
- out_rs2  output  5  source register 2
- out_rd  output  5  destination register
- out_imm  output  32 signed  decoded immediate
- out_src2_imm  output  1  ALU r2 operand takes out_imm instead of rs2 data
- out_rd_we  output  1  result is written back
- out_is_branch  output  1  BEQ; EQL result is the taken flag
- out_illegal  output  1  unsupported encoding; all other fields don't-care except out_pc
- out_pc  output  32  in_pc carried through
- illegal_count  output  CNT_W  saturating count of illegal entries accepted

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, in_ready=1.
  - Both buffer entries invalid; illegal_count=0.
  - All data outputs 0; out_alu_func=ADD.
- Input handshake: accept when in_valid&&in_ready. Output handshake: transfer when out_valid&&out_ready.
- Latency: an instruction accepted in cycle N appears on the outputs in cycle N+1 if the main entry is empty or draining.
- Buffering:
  - Main entry drives the outputs.
  - Skid entry captures an accepted word when the main entry is valid and not draining.
  - in_ready (registered) = skid entry empty.
  - When main drains, skid moves to main in the same cycle.
  - Order is strictly FIFO; no drops or duplicates under any stall pattern.
- Simultaneous accept+drain with skid empty: main loads the new entry; out_valid stays 1.
- Decode (opcode instr[6:0]):
  - 0110011 R-type, funct7 0000000:
    - funct3 000 ADD, 001 SLL, 010 SLT, 100 XOR, 101 SRL, 110 OR, 111 AND.
    - 011 (SLTU) is illegal.
  - 0110011 R-type, funct7 0100000:
    - funct3 000 SUB, 101 SRA.
    - Any other funct3 or funct7 is illegal.
  - 0010011 I-type:
    - funct3 000 gives ADDI, with out_src2_imm=0 and the ALU adding imm internally.
    - 010 SLT, 100 XOR, 110 OR, 111 AND use out_src2_imm=1.
    - Immediate = sign-extended instr[31:20].
  - Shift immediates:
    - 001 SLL with funct7 0000000; 101 SRL with funct7 0000000; 101 SRA with funct7 0100000; all with out_src2_imm=1.
    - Immediate = zero-extended instr[24:20].
    - Other funct7 is illegal. 011 (SLTIU) is illegal.
  - 1100011 funct3 000 (BEQ):
    - EQL, out_is_branch=1, out_rd_we=0.
    - imm = sign-extended {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}.
    - Other branch funct3 are illegal.
  - All other opcodes are illegal.
- Field extraction: rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7].
- out_rd_we = 1 only for legal R/I-type with rd≠0; 0 for rd=x0, branches and illegal entries.
- Illegal entry: out_illegal=1, out_alu_func=ADD, out_rd_we=0, out_is_branch=0.
- illegal_count:
  - Increments when an illegal word is accepted, not when it is presented.
  - Saturates at 2^CNT_W−1.
- Flush:
  - Next edge invalidates both entries: out_valid=0, in_ready=1.
  - An input offered in the flush cycle is discarded.
  - illegal_count is unaffected.
- Reset mid-stall discards all entries immediately (async).

Test Plan:
- 0x002081B3 (add x3,x1,x2), out_ready=1 -> next cycle out_valid=1, ADD, rs1=1, rs2=2, rd=3, rd_we=1, src2_imm=0, illegal=0.
- 0x407302B3 (sub x5,x6,x7) then 0xFFF00093 (addi x1,x0,-1) -> SUB rd=5; then ADDI imm=0xFFFFFFFF, rd=1, rd_we=1.
- 0x00208463 (beq x1,x2,+8) -> EQL, is_branch=1, rd_we=0, imm=8.
  - 0x40515193 (srai x3,x2,5) -> SRA, src2_imm=1, imm=5.
- out_ready=0 for 3 cycles, two back-to-back valid words -> both accepted, in_ready=0 after the second. Then out_ready=1 -> both emerge in order on consecutive cycles, in_ready=1 again.
- 0x00000000 and 0x0020B1B3 (sltu) accepted -> out_illegal=1 for each, rd_we=0, illegal_count=2.
  - With CNT_W=2, five illegal words -> count holds 3.
- Stall with two entries buffered, assert flush -> next cycle out_valid=0, in_ready=1, buffered entries never appear.
  - rst pulse mid-stall -> outputs reset values immediately.

Source files
------------

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: turns fetched RV32I words into ALU commands and holds
// them in a two-entry skid buffer so the fetch-side ready comes from a flop.
package decode_issue_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_SRA  = 4'd6,
    ALU_AND  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_ADDI = 4'd9,
    ALU_EQL  = 4'd10
  } ALU_func_t;

  typedef struct packed {
    ALU_func_t   alu_func;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        src2_imm;
    logic        rd_we;
    logic        is_branch;
    logic        illegal;
    logic [31:0] pc;
  } entry_t;
endpackage

module decode_issue_stage
  import decode_issue_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [31:0]       in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output ALU_func_t         out_alu_func,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rd,
  output logic signed [31:0] out_imm,
  output logic              out_src2_imm,
  output logic              out_rd_we,
  output logic              out_is_branch,
  output logic              out_illegal,
  output logic [31:0]       out_pc,
  output logic [CNT_W-1:0]  illegal_count
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;
  entry_t     dec;

  logic       main_valid_q, main_valid_d;
  logic       skid_valid_q, skid_valid_d;
  entry_t     main_q, main_d;
  entry_t     skid_q, skid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic       accept;
  logic       drain;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  always_comb begin
    dec           = '0;
    legal         = 1'b0;
    dec.alu_func  = ALU_ADD;
    dec.rs1       = in_instr[19:15];
    dec.rs2       = in_instr[24:20];
    dec.rd        = in_instr[11:7];
    dec.pc        = in_pc;
    case (opcode)
      7'b0110011: begin
        if (funct7 == 7'b0000000) begin
          legal = 1'b1;
          case (funct3)
            3'b000:  dec.alu_func = ALU_ADD;
            3'b001:  dec.alu_func = ALU_SLL;
            3'b010:  dec.alu_func = ALU_SLT;
            3'b100:  dec.alu_func = ALU_XOR;
            3'b101:  dec.alu_func = ALU_SRL;
            3'b110:  dec.alu_func = ALU_OR;
            3'b111:  dec.alu_func = ALU_AND;
            default: legal = 1'b0;
          endcase
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000) begin
            legal        = 1'b1;
            dec.alu_func = ALU_SUB;
          end else if (funct3 == 3'b101) begin
            legal        = 1'b1;
            dec.alu_func = ALU_SRA;
          end
        end
      end
      7'b0010011: begin
        dec.imm      = {{20{in_instr[31]}}, in_instr[31:20]};
        dec.src2_imm = 1'b1;
        legal        = 1'b1;
        case (funct3)
          3'b000: begin
            dec.alu_func = ALU_ADDI;
            dec.src2_imm = 1'b0;
          end
          3'b010: dec.alu_func = ALU_SLT;
          3'b100: dec.alu_func = ALU_XOR;
          3'b110: dec.alu_func = ALU_OR;
          3'b111: dec.alu_func = ALU_AND;
          3'b001: begin
            dec.imm      = {27'd0, in_instr[24:20]};
            dec.alu_func = ALU_SLL;
            legal        = (funct7 == 7'b0000000);
          end
          3'b101: begin
            dec.imm      = {27'd0, in_instr[24:20]};
            dec.alu_func = (funct7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
            legal        = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          end
          default: legal = 1'b0;
        endcase
      end
      7'b1100011: begin
        if (funct3 == 3'b000) begin
          legal         = 1'b1;
          dec.alu_func  = ALU_EQL;
          dec.is_branch = 1'b1;
          dec.imm       = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                           in_instr[11:8], 1'b0};
        end
      end
      default: legal = 1'b0;
    endcase
    // Illegal entries carry a neutral command so downstream never acts on them.
    if (legal) begin
      dec.rd_we = !dec.is_branch && (dec.rd != 5'd0);
    end else begin
      dec.illegal   = 1'b1;
      dec.alu_func  = ALU_ADD;
      dec.rd_we     = 1'b0;
      dec.is_branch = 1'b0;
      dec.src2_imm  = 1'b0;
    end
  end

  assign accept = in_valid && in_ready && !flush;
  assign drain  = main_valid_q && out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    count_d      = count_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain) begin
      // A full skid blocks acceptance, so only one source can refill main.
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    if (accept && dec.illegal && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
      count_q      <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      count_q      <= count_d;
    end
  end

  assign in_ready      = !skid_valid_q;
  assign out_valid     = main_valid_q;
  assign out_alu_func  = main_q.alu_func;
  assign out_rs1       = main_q.rs1;
  assign out_rs2       = main_q.rs2;
  assign out_rd        = main_q.rd;
  assign out_imm       = main_q.imm;
  assign out_src2_imm  = main_q.src2_imm;
  assign out_rd_we     = main_q.rd_we;
  assign out_is_branch = main_q.is_branch;
  assign out_illegal   = main_q.illegal;
  assign out_pc        = main_q.pc;
  assign illegal_count = count_q;

endmodule
